// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS main control FSM: walks fetch/decode/execute/memory/writeback
// and drives datapath selects, write enables and the aluop code for aludec.
module mc_ctrl_fsm #(
  parameter int OPW = 6,
  parameter int STW = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] op,
  input  logic           memrdy,
  output logic           pcwrite,
  output logic           branch,
  output logic           irwrite,
  output logic           regwrite,
  output logic           memwrite,
  output logic           iord,
  output logic           memtoreg,
  output logic           regdst,
  output logic           alusrca,
  output logic [1:0]     alusrcb,
  output logic [1:0]     pcsrc,
  output logic [1:0]     aluop,
  output logic [STW-1:0] state,
  output logic           illegal
);

  typedef enum logic [STW-1:0] {
    S_FETCH   = STW'(0),
    S_DECODE  = STW'(1),
    S_MEMADR  = STW'(2),
    S_MEMRD   = STW'(3),
    S_MEMWB   = STW'(4),
    S_MEMWR   = STW'(5),
    S_RTYPEEX = STW'(6),
    S_RTYPEWB = STW'(7),
    S_BEQEX   = STW'(8),
    S_ADDIEX  = STW'(9),
    S_ADDIWB  = STW'(10),
    S_JEX     = STW'(11)
  } state_t;

  localparam logic [OPW-1:0] OP_LW   = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW   = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_RTYP = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b001000);
  localparam logic [OPW-1:0] OP_J    = OPW'(6'b000010);

  state_t state_reg;
  state_t state_next;
  state_t out_state;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_FETCH;
    else       state_reg <= state_next;
  end

  assign state = state_reg;

  always_comb begin
    pcwrite    = 1'b0;
    branch     = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    memwrite   = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    aluop      = 2'b00;
    illegal    = 1'b0;
    state_next = state_reg;
    // Under reset the selects show FETCH values; enables are cleared below.
    out_state  = reset ? S_FETCH : state_reg;

    case (out_state)
      S_FETCH: begin
        alusrcb = 2'b01;
        pcwrite = memrdy;
        irwrite = memrdy;
        if (memrdy) state_next = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYP:      state_next = S_RTYPEEX;
          OP_BEQ:       state_next = S_BEQEX;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JEX;
          default: begin
            state_next = S_FETCH;
            illegal    = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        state_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (memrdy) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite   = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        if (memrdy) state_next = S_FETCH;
      end
      S_RTYPEEX: begin
        alusrca    = 1'b1;
        aluop      = 2'b10;
        state_next = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regdst     = 1'b1;
        regwrite   = 1'b1;
        state_next = S_FETCH;
      end
      S_BEQEX: begin
        alusrca    = 1'b1;
        aluop      = 2'b01;
        pcsrc      = 2'b01;
        branch     = 1'b1;
        state_next = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        state_next = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite   = 1'b1;
        state_next = S_FETCH;
      end
      S_JEX: begin
        pcsrc      = 2'b10;
        pcwrite    = 1'b1;
        state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase

    if (reset) begin
      pcwrite  = 1'b0;
      branch   = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
      memwrite = 1'b0;
      illegal  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: per-instruction state-path model checked every cycle,
// plus hand-computed latency / pulse-count expectations per instruction.
module tb_mc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'd0;
  logic       memrdy = 1'b1;
  logic       pcwrite, branch, irwrite, regwrite, memwrite, iord, memtoreg;
  logic       regdst, alusrca, illegal;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic [3:0] state;

  int tests = 0;
  int fails = 0;

  mc_ctrl_fsm #(.OPW(6), .STW(4)) dut (
    .clk(clk), .reset(reset), .op(op), .memrdy(memrdy),
    .pcwrite(pcwrite), .branch(branch), .irwrite(irwrite), .regwrite(regwrite),
    .memwrite(memwrite), .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop),
    .state(state), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  // Control word order: pcwrite,branch,irwrite,regwrite,memwrite,iord,memtoreg,
  // regdst,alusrca,alusrcb[1:0],pcsrc[1:0],aluop[1:0]
  function automatic logic [14:0] mk(input logic pw, br, iw, rw, mw, io, m2r, rd, asa,
                                     input logic [1:0] asb, pcs, aop);
    return {pw, br, iw, rw, mw, io, m2r, rd, asa, asb, pcs, aop};
  endfunction

  function automatic logic [14:0] ctl_of(input int s);
    case (s)
      0:  return mk(0,0,0,0,0,0,0,0,0,2'b01,2'b00,2'b00);
      1:  return mk(0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00);
      2:  return mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00);
      3:  return mk(0,0,0,0,0,1,0,0,0,2'b00,2'b00,2'b00);
      4:  return mk(0,0,0,1,0,0,1,0,0,2'b00,2'b00,2'b00);
      5:  return mk(0,0,0,0,1,1,0,0,0,2'b00,2'b00,2'b00);
      6:  return mk(0,0,0,0,0,0,0,0,1,2'b00,2'b00,2'b10);
      7:  return mk(0,0,0,1,0,0,0,1,0,2'b00,2'b00,2'b00);
      8:  return mk(0,1,0,0,0,0,0,0,1,2'b00,2'b01,2'b01);
      9:  return mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00);
      10: return mk(0,0,0,1,0,0,0,0,0,2'b00,2'b00,2'b00);
      11: return mk(1,0,0,0,0,0,0,0,0,2'b00,2'b10,2'b00);
      default: return 15'd0;
    endcase
  endfunction

  function automatic logic supported(input logic [5:0] o);
    return (o == 6'b100011) || (o == 6'b101011) || (o == 6'b000000) ||
           (o == 6'b000100) || (o == 6'b001000) || (o == 6'b000010);
  endfunction

  // Model: each instruction is a fixed list of states; FETCH/MEMRD/MEMWR wait on memrdy.
  int mpath[6] = '{0, 1, 0, 0, 0, 0};
  int mlen = 2;
  int midx = 0;
  bit chk_en = 0;

  always @(posedge clk) begin
    int s;
    if (reset) begin
      mpath[0] = 0; mpath[1] = 1; mlen = 2; midx = 0;
    end else begin
      s = mpath[midx];
      if (s == 1) begin
        case (op)
          6'b100011: begin mpath[2] = 2; mpath[3] = 3; mpath[4] = 4; mlen = 5; end
          6'b101011: begin mpath[2] = 2; mpath[3] = 5; mlen = 4; end
          6'b000000: begin mpath[2] = 6; mpath[3] = 7; mlen = 4; end
          6'b000100: begin mpath[2] = 8; mlen = 3; end
          6'b001000: begin mpath[2] = 9; mpath[3] = 10; mlen = 4; end
          6'b000010: begin mpath[2] = 11; mlen = 3; end
          default:   mlen = 2;
        endcase
      end
      if (!((s == 0 || s == 3 || s == 5) && !memrdy)) begin
        midx++;
        if (midx >= mlen) midx = 0;
      end
    end
    chk_en = 1;
  end

  always @(negedge clk) begin
    int s;
    logic [14:0] w;
    logic il;
    if (chk_en) begin
      s = mpath[midx];
      if (reset) begin
        w = ctl_of(0);
        il = 1'b0;
      end else begin
        w = ctl_of(s);
        if (s == 0) begin
          w[14] = memrdy;
          w[12] = memrdy;
        end
        il = (s == 1) && !supported(op);
      end
      check("cycle", {12'd0, state, illegal, pcwrite, branch, irwrite, regwrite, memwrite,
                      iord, memtoreg, regdst, alusrca, alusrcb, pcsrc, aluop},
                     {12'd0, 4'(s), il, w});
    end
  end

  task automatic run_instr(input logic [5:0] op_i, input int fetch_stall, input int wr_stall,
                           output int cycles, output int mw_cnt, output int rw_cnt,
                           output int il_cnt);
    int fs, ws;
    bit saw_decode, done;
    fs = fetch_stall; ws = wr_stall;
    cycles = 0; mw_cnt = 0; rw_cnt = 0; il_cnt = 0;
    saw_decode = 0; done = 0;
    op = op_i;
    while (!done && cycles < 50) begin
      if (state == 4'd0 && fs > 0) begin memrdy = 1'b0; fs--; end
      else if (state == 4'd5 && ws > 0) begin memrdy = 1'b0; ws--; end
      else memrdy = 1'b1;
      @(negedge clk);
      cycles++;
      mw_cnt += int'(memwrite);
      rw_cnt += int'(regwrite);
      il_cnt += int'(illegal);
      if (state == 4'd1) saw_decode = 1;
      @(posedge clk); #1;
      if (saw_decode && state == 4'd0) done = 1;
    end
    memrdy = 1'b1;
    if (!done) check("timeout", 32'd0, 32'd1);
    $display("[TB] op=%b cycles=%0d memwrite=%0d regwrite=%0d illegal=%0d",
             op_i, cycles, mw_cnt, rw_cnt, il_cnt);
  endtask

  initial begin
    int c, mw, rw, il, n;
    reset = 1'b1; memrdy = 1'b1; op = 6'd0;
    @(posedge clk); #1;
    @(negedge clk);
    check("reset_state", {28'd0, state}, 32'd0);
    check("reset_enables", {27'd0, pcwrite, irwrite, regwrite, memwrite, illegal}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("first_fetch", {28'd0, pcwrite, irwrite, aluop}, 32'b1100);
    @(posedge clk); #1;
    // second FETCH cycle after the first instruction is fetched: now in DECODE
    while (state != 4'd0) begin @(posedge clk); #1; end

    run_instr(6'b100011, 0, 0, c, mw, rw, il);
    check("lw_cycles", c, 5);   check("lw_regwrite", rw, 1);
    run_instr(6'b101011, 0, 0, c, mw, rw, il);
    check("sw_cycles", c, 4);   check("sw_memwrite", mw, 1);
    run_instr(6'b000000, 0, 0, c, mw, rw, il);
    check("rtype_cycles", c, 4); check("rtype_regwrite", rw, 1);
    run_instr(6'b000100, 0, 0, c, mw, rw, il);
    check("beq_cycles", c, 3);  check("beq_regwrite", rw, 0);
    run_instr(6'b001000, 0, 0, c, mw, rw, il);
    check("addi_cycles", c, 4);
    run_instr(6'b000010, 0, 0, c, mw, rw, il);
    check("j_cycles", c, 3);
    run_instr(6'b101011, 2, 3, c, mw, rw, il);
    check("sw_stall_cycles", c, 9); check("sw_stall_memwrite", mw, 4);
    run_instr(6'b100011, 0, 0, c, mw, rw, il);
    check("lw_again_cycles", c, 5);
    run_instr(6'b111111, 0, 0, c, mw, rw, il);
    check("illegal_cycles", c, 2); check("illegal_pulses", il, 1);

    // Abandon an R-type in RTYPEEX with reset: no register write may follow.
    op = 6'b000000; memrdy = 1'b1;
    n = 0;
    while (state != 4'd6 && n < 10) begin @(posedge clk); #1; n++; end
    check("reach_rtypeex", {28'd0, state}, 32'd6);
    reset = 1'b1;
    @(negedge clk);
    rw = int'(regwrite);
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_state", {28'd0, state}, 32'd0);
    @(negedge clk);
    rw += int'(regwrite);
    check("abort_no_regwrite", rw, 0);
    @(posedge clk); #1;
    n = 0;
    while (state != 4'd0 && n < 10) begin @(posedge clk); #1; n++; end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
